// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: conditions the asynchronous PS/2 clock/data, deserialises
// 11-bit frames and folds E0/F0 prefixes into flags on the following scancode.
module ps2_kbd_rx #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 16384
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_strobe,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_released,
    output logic       key_strobe,
    output logic       frame_error
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    // Odd parity across the eight data bits and the parity bit.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    logic                  clk_meta_q, clk_sync_q;
    logic                  dat_meta_q, dat_sync_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fclk_q, fclk_d;
    logic                  sample_s;

    state_t                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_q, par_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  ext_pend_q, ext_pend_d;
    logic                  rel_pend_q, rel_pend_d;

    logic [7:0]            byte_data_q, byte_data_d;
    logic                  byte_strobe_q, byte_strobe_d;
    logic [7:0]            key_code_q, key_code_d;
    logic                  key_ext_q, key_ext_d;
    logic                  key_rel_q, key_rel_d;
    logic                  key_strobe_q, key_strobe_d;
    logic                  frame_err_q, frame_err_d;

    // A falling edge of the filtered clock is seen when the all-zero taps meet a high level.
    assign sample_s = fclk_q && (filt_q == {FILTER_LEN{1'b0}});

    // Next-state logic: clock filter, frame deserialiser, watchdog and prefix folding.
    always_comb begin
        filt_d        = {filt_q[FILTER_LEN-2:0], clk_sync_q};
        fclk_d        = fclk_q;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        wd_d          = wd_q;
        ext_pend_d    = ext_pend_q;
        rel_pend_d    = rel_pend_q;
        byte_data_d   = byte_data_q;
        byte_strobe_d = 1'b0;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        key_rel_d     = key_rel_q;
        key_strobe_d  = 1'b0;
        frame_err_d   = 1'b0;

        if (filt_q == {FILTER_LEN{1'b0}}) begin
            fclk_d = 1'b0;
        end else if (filt_q == {FILTER_LEN{1'b1}}) begin
            fclk_d = 1'b1;
        end else begin
            fclk_d = fclk_q;
        end

        case (state_q)
            ST_IDLE: begin
                wd_d = {WD_W{1'b0}};
                if (sample_s && !dat_sync_q) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = 4'd1;
                    par_d     = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (sample_s) begin
                    wd_d = {WD_W{1'b0}};
                    if (bit_cnt_q <= 4'd8) begin
                        shift_d   = {dat_sync_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (bit_cnt_q == 4'd9) begin
                        par_d     = dat_sync_q;
                        bit_cnt_d = 4'd10;
                    end else begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = 4'd0;
                        if (odd_parity_ok({par_q, shift_q}) && dat_sync_q) begin
                            byte_data_d   = shift_q;
                            byte_strobe_d = 1'b1;
                            if (shift_q == 8'hE0) begin
                                ext_pend_d = 1'b1;
                            end else if (shift_q == 8'hF0) begin
                                rel_pend_d = 1'b1;
                            end else begin
                                key_code_d   = shift_q;
                                key_ext_d    = ext_pend_q;
                                key_rel_d    = rel_pend_q;
                                key_strobe_d = 1'b1;
                                ext_pend_d   = 1'b0;
                                rel_pend_d   = 1'b0;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            ext_pend_d  = 1'b0;
                            rel_pend_d  = 1'b0;
                        end
                    end
                end else if (wd_q == WD_LAST) begin
                    // Truncated frame: abandon it and forget any half-received prefix.
                    state_d     = ST_IDLE;
                    bit_cnt_d   = 4'd0;
                    frame_err_d = 1'b1;
                    ext_pend_d  = 1'b0;
                    rel_pend_d  = 1'b0;
                end else begin
                    wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 4'd0;
            end
        endcase
    end

    // State registers; synchronisers and filter reset idle-high so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q    <= 1'b1;
            clk_sync_q    <= 1'b1;
            dat_meta_q    <= 1'b1;
            dat_sync_q    <= 1'b1;
            filt_q        <= {FILTER_LEN{1'b1}};
            fclk_q        <= 1'b1;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 8'h00;
            par_q         <= 1'b0;
            wd_q          <= {WD_W{1'b0}};
            ext_pend_q    <= 1'b0;
            rel_pend_q    <= 1'b0;
            byte_data_q   <= 8'h00;
            byte_strobe_q <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_rel_q     <= 1'b0;
            key_strobe_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            clk_meta_q    <= ps2_clk;
            clk_sync_q    <= clk_meta_q;
            dat_meta_q    <= ps2_data;
            dat_sync_q    <= dat_meta_q;
            filt_q        <= filt_d;
            fclk_q        <= fclk_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            wd_q          <= wd_d;
            ext_pend_q    <= ext_pend_d;
            rel_pend_q    <= rel_pend_d;
            byte_data_q   <= byte_data_d;
            byte_strobe_q <= byte_strobe_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            key_rel_q     <= key_rel_d;
            key_strobe_q  <= key_strobe_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign byte_data    = byte_data_q;
    assign byte_strobe  = byte_strobe_q;
    assign key_code     = key_code_q;
    assign key_extended = key_ext_q;
    assign key_released = key_rel_q;
    assign key_strobe   = key_strobe_q;
    assign frame_error  = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: a frame-level keyboard model predicts bytes, keys and errors.
module tb_ps2_kbd_rx;

    localparam int FL   = 4;
    localparam int TO   = 512;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] byte_data;
    logic       byte_strobe;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_released;
    logic       key_strobe;
    logic       frame_error;

    ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .byte_data(byte_data), .byte_strobe(byte_strobe),
        .key_code(key_code), .key_extended(key_extended), .key_released(key_released),
        .key_strobe(key_strobe), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_byte_q[$];
    logic [9:0] exp_key_q[$];
    bit         exp_err_q[$];
    bit         m_ext = 1'b0;
    bit         m_rel = 1'b0;
    int         last_fall_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Keyboard model at frame level: what a complete frame means to the key matrix.
    function automatic void model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            exp_err_q.push_back(1'b0);
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else begin
            exp_byte_q.push_back(b);
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_rel = 1'b1;
            else begin
                exp_key_q.push_back({b, m_ext, m_rel});
                m_ext = 1'b0;
                m_rel = 1'b0;
            end
        end
    endfunction

    task automatic ps2_bit(input logic d);
        ps2_data = d;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    // Sends the first nbits bits of a frame; only full frames are fed to the model here.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        if (nbits == 11) model_frame(b, !bad_par);
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    endtask

    // Monitor: every strobe pops the matching expectation.
    always @(negedge clk) begin
        if (byte_strobe) begin
            if (exp_byte_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_byte_strobe: got byte %0h, required none", byte_data);
            end else chk("byte_data", 32'(byte_data), 32'(exp_byte_q.pop_front()));
        end
        if (key_strobe) begin
            if (exp_key_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_key_strobe: got key %0h, required none", key_code);
            end else chk("key_code_ext_rel", 32'({key_code, key_extended, key_released}),
                         32'(exp_key_q.pop_front()));
        end
        if (frame_error) begin
            if (exp_err_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_frame_error: got 1, required 0");
            end else begin
                checks++;
                if (exp_err_q.pop_front()) begin
                    checks++;
                    if ((cyc - last_fall_cyc) < TO + FL + 2 || (cyc - last_fall_cyc) > TO + FL + 4) begin
                        errors++;
                        $display("FAIL timeout_latency: got %0d cycles, required %0d..%0d",
                                 cyc - last_fall_cyc, TO + FL + 2, TO + FL + 4);
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs();
        @(negedge clk);
        chk("rst_byte_data", 32'(byte_data), 32'h0);
        chk("rst_key_code", 32'(key_code), 32'h0);
        chk("rst_flags_strobes", 32'({key_extended, key_released, byte_strobe, key_strobe, frame_error}), 32'h0);
    endtask

    initial begin
        logic [7:0] b;
        int         pick;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        check_reset_outputs();
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(posedge clk);

        send_frame(8'h1C, 1'b0, 11);
        repeat (60) @(posedge clk);
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h75, 1'b0, 11);
        send_frame(8'h75, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b1, 11);
        send_frame(8'h1C, 1'b0, 11);
        repeat (60) @(posedge clk);

        // Truncated frame after five bits: watchdog error expected, pending prefix dropped.
        send_frame(8'hE0, 1'b0, 11);
        exp_err_q.push_back(1'b1);
        m_ext = 1'b0;
        m_rel = 1'b0;
        send_frame(8'h29, 1'b0, 5);
        repeat (TO + 60) @(posedge clk);
        send_frame(8'h29, 1'b0, 11);
        repeat (60) @(posedge clk);

        // Two-cycle low glitch with data low must not start a frame.
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (2) @(posedge clk);
        #1 ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (40) @(posedge clk);
        send_frame(8'h16, 1'b0, 11);
        repeat (60) @(posedge clk);

        // Reset in mid-frame after a pending F0.
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h5A, 1'b0, 5);
        #1 reset = 1'b1;
        m_ext = 1'b0;
        m_rel = 1'b0;
        repeat (3) @(posedge clk);
        check_reset_outputs();
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        send_frame(8'h5A, 1'b0, 11);

        // Randomised back-to-back traffic mixing prefixes, special codes and parity errors.
        for (int n = 0; n < 30; n++) begin
            pick = $urandom_range(0, 5);
            case (pick)
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = ($urandom_range(0, 1) == 0) ? 8'hE1 : 8'hAA;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_frame(b, $urandom_range(0, 7) == 0, 11);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 100)) @(posedge clk);
        end

        repeat (200) @(posedge clk);
        chk("pending_bytes", 32'(exp_byte_q.size()), 32'h0);
        chk("pending_keys", 32'(exp_key_q.size()), 32'h0);
        chk("pending_errors", 32'(exp_err_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

Receives the PS/2 keyboard stream driven by the MiST user_io block (ps2_kbd_clk / ps2_kbd_data) and turns it into complete scancode events for the core's keyboard matrix. It:
- deserialises 11-bit frames and checks start, odd parity and stop bits;
- folds the E0 (extended) and F0 (release) prefixes into flags on the following code byte;
- recovers from truncated frames with a watchdog.

It sits between user_io and the core's key-matrix translator.

## Interface
Parameters:
- FILTER_LEN, 4: consecutive identical samples required before the filtered PS/2 clock changes level (2..8).
- TIMEOUT, 16384: clk cycles without a sample event, mid-frame, before the frame is abandoned. Must exceed one PS/2 bit period at the slowest ps2_clk.

Ports:
- clk  in  1  system clock; only clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock from user_io ps2_kbd_clk; asynchronous to clk; idles high.
- ps2_data  in  1  PS/2 data from user_io ps2_kbd_data; asynchronous to clk.
- byte_data  out  8  last correctly received raw byte.
- byte_strobe  out  1  one-cycle pulse when byte_data updates.
- key_code  out  8  last non-prefix code byte.
- key_extended  out  1  an E0 prefix preceded key_code.
- key_released  out  1  an F0 prefix preceded key_code.
- key_strobe  out  1  one-cycle pulse when the key_* outputs update.
- frame_error  out  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation
Input conditioning:
- ps2_clk and ps2_data each pass through a 2-FF synchroniser.
- Synchronised ps2_clk feeds a FILTER_LEN-deep shift register. The filtered clock goes low only when all taps are 0 and high only when all taps are 1; otherwise it holds.
- A sample event is a 1→0 transition of the filtered clock. Synchronised ps2_data is sampled in that cycle. user_io changes data on the rising ps2_clk edge, so data is stable at the falling edge.

Frame state machine (bit counter 0..10):
- IDLE:
  - On a sample event with data=0 (start bit): go to RECV, bit counter=1, parity accumulator=0.
  - On a sample event with data=1: ignored; stay in IDLE; no error.
- RECV, bits 1..8: data shifted in LSB first. Bit 9: parity. Bit 10: stop.
- At bit 10, return to IDLE. The frame is valid when XOR(data bits, parity bit)=1 and stop=1.
  - Valid: byte_data←byte, byte_strobe=1.
  - Invalid: frame_error=1, no byte_strobe, both prefix flags cleared.
- Watchdog:
  - Counter clears on every sample event and while in IDLE.
  - In RECV, when it reaches TIMEOUT-1: return to IDLE, pulse frame_error, clear the prefix flags.
  - The counter saturates and does not wrap.

Prefix folding (on each valid byte):
- 0xE0: set ext_pending; no key_strobe.
- 0xF0: set rel_pending; no key_strobe.
- Any other value, including 0xE1 and 0xAA:
  - key_code←byte, key_extended←ext_pending, key_released←rel_pending, key_strobe=1;
  - both pending flags cleared in the same cycle.
- Repeated prefixes (E0 E0, F0 F0) leave the flag set and have no further effect.

Reset:
- All outputs 0: byte_data=0x00, key_code=0x00, all strobes and flags 0.
- State=IDLE, bit counter=0, pending flags=0, watchdog=0.
- Filter taps and synchronisers reset to 1 (idle-high), so reset never produces a sample event.
- Reset mid-frame discards the partial frame. The next low sample is treated as a start bit. Any misframing this causes is recovered by the parity/stop check or the watchdog.

## Timing
- Sample event latency from a ps2_clk fall: 2 synchroniser cycles + FILTER_LEN cycles.
- byte_strobe, key_strobe and frame_error are asserted in the cycle after the stop-bit sample event (or the watchdog expiry). Each lasts exactly one cycle.
- byte_strobe and key_strobe coincide for non-prefix bytes.
- Data outputs change only in a strobe cycle and hold otherwise.
- Back-to-back frames (stop bit followed by the next start bit one PS/2 period later) are received without loss; no idle gap is required.
- No back-pressure: the consumer must accept a strobe in the cycle it occurs.

## Test plan
- Single frame 0x1C (parity 0, stop 1) at 15 kHz, clk 28 MHz → byte_strobe once with byte_data=0x1C; key_strobe with key_code=0x1C, extended=0, released=0.
- Sequence E0 F0 75 → three byte_strobes; exactly one key_strobe, with key_code=0x75, key_extended=1, key_released=1. A following 0x75 gives extended=0, released=0.
- F0 then a frame 0x1C with a wrong parity bit → frame_error pulse, no strobe for 0x1C. The next valid 0x1C reports released=0.
- Frame stopped after 5 bits, then idle → frame_error exactly TIMEOUT cycles after the last sample event. A subsequent 0x29 frame is received correctly.
- 2-cycle low glitch on ps2_clk with FILTER_LEN=4 → no sample event, no state change.
- Reset asserted after bit 4 of a frame, released, then a full 0x5A frame → outputs 0 during reset, then key_code=0x5A.
